fifo_word_unpacker: RTL and testbench

//  Downstream consumer of the 64-bit word FIFO. Pulls a programmed number of

---
 rtl/fifo_word_unpacker.sv | 109 ++++++++++
 tb/tb_fifo_word_unpacker.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_word_unpacker.sv
// rtl/fifo_word_unpacker.sv - pulls FIFO words and streams them out as LSB-first elements
module fifo_word_unpacker #(
    parameter int BITLEN    = 64,
    parameter int ELEM_BITS = 8,
    parameter int LEN_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LEN_BITS-1:0]  frame_len,
    input  logic                 fifo_empty,
    input  logic [BITLEN-1:0]    fifo_dout,
    output logic                 fifo_rd_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ELEM_BITS-1:0] out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
);
    localparam int NUM_ELEM = BITLEN / ELEM_BITS;
    localparam int CNT_W    = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
    localparam logic [CNT_W-1:0]    LAST_ELEM = CNT_W'(NUM_ELEM - 1);
    localparam logic [LEN_BITS-1:0] ONE_WORD  = LEN_BITS'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPT,
        S_EMIT,
        S_DONE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [LEN_BITS-1:0] words_left;
    logic [CNT_W-1:0]    elem_cnt;
    logic [BITLEN-1:0]   shreg;
    logic                accept;
    logic                word_end;

    assign accept   = (state == S_EMIT) && out_ready;
    assign word_end = accept && (elem_cnt == LAST_ELEM);
    assign out_data = shreg[ELEM_BITS-1:0];
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            words_left <= '0;
            elem_cnt   <= '0;
            shreg      <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && start) begin
                words_left <= frame_len;
            end
            if (state == S_CAPT) begin
                shreg    <= fifo_dout;
                elem_cnt <= '0;
            end
            if (accept) begin
                // Fully shifted word leaves shreg at zero, so out_data idles at 0
                shreg    <= shreg >> ELEM_BITS;
                elem_cnt <= word_end ? '0 : elem_cnt + 1'b1;
            end
            if (word_end) begin
                words_left <= words_left - 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        fifo_rd_en = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (frame_len == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                // Gated by rst_n so a reset cycle never consumes a FIFO word
                fifo_rd_en = rst_n && !fifo_empty;
                if (!fifo_empty) begin
                    state_nxt = S_CAPT;
                end
            end
            S_CAPT: begin
                state_nxt = S_EMIT;
            end
            S_EMIT: begin
                out_valid = 1'b1;
                out_last  = (words_left == ONE_WORD) && (elem_cnt == LAST_ELEM);
                if (word_end) begin
                    state_nxt = (words_left == ONE_WORD) ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_fifo_word_unpacker.sv
// tb/tb_fifo_word_unpacker.sv - frame table plus scoreboard bench for fifo_word_unpacker
module tb_fifo_word_unpacker;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] frame_len;
    logic        fifo_empty;
    logic [63:0] fifo_dout;
    logic        fifo_rd_en;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    fifo_word_unpacker #(.BITLEN(64), .ELEM_BITS(8), .LEN_BITS(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .frame_len  (frame_len),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    // FIFO model: a plain array with pointers, data valid the cycle after rd_en
    logic [63:0] mem [0:255];
    int          wr_ptr;
    int          rd_ptr;
    logic        hold_empty;
    assign fifo_empty = hold_empty || (wr_ptr == rd_ptr);

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        string       name;
        int          len;
        int          empty_cyc;
        int          ready_mode;
        logic [63:0] seed;
        bit          busy_start;
        bit          push;
        int          exp_rd;
        int          exp_acc;
        int          exp_last;
        int          exp_first;
    } vec_t;
    vec_t vecs[6];

    int nchk, npass, cyc;
    int rd_count, acc_count, last_count, done_count;
    int first_valid, done_cyc, last_acc_cyc;
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        nchk++;
        if (got === want) npass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, want);
    endtask

    task automatic expect_word(input logic [63:0] w, input bit last_word);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.data = w[8*i +: 8];
            e.last = last_word && (i == 7);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_word(input logic [63:0] w, input bit last_word);
        mem[wr_ptr[7:0]] = w;
        wr_ptr++;
        expect_word(w, last_word);
    endtask

    task automatic clear_stats();
        rd_count = 0; acc_count = 0; last_count = 0; done_count = 0;
        first_valid = -1; done_cyc = -1; last_acc_cyc = -1; cyc = 0;
    endtask

    // One clock: sample/score the current cycle, advance, then update the FIFO model
    task automatic tick();
        logic rd;
        exp_t e;
        #1;
        rd = fifo_rd_en;
        if (rd) begin
            rd_count++;
            chk("rd_while_empty", fifo_empty, 0);
        end
        if (prev_stall && rst_n) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, prev_data);
            chk("stall_last", out_last, prev_last);
        end
        if (out_valid && first_valid < 0) first_valid = cyc;
        if (out_valid && out_ready && rst_n) begin
            acc_count++;
            if (exp_q.size() == 0) begin
                chk("unexpected_elem", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("elem_data", out_data, e.data);
                chk("elem_last", out_last, e.last);
            end
            if (out_last) begin
                last_count++;
                last_acc_cyc = cyc;
            end
        end
        if (done) begin
            done_count++;
            done_cyc = cyc;
        end
        prev_stall = out_valid && !out_ready && rst_n;
        prev_data  = out_data;
        prev_last  = out_last;
        @(posedge clk);
        #1;
        if (rd) begin
            fifo_dout = mem[rd_ptr[7:0]];
            rd_ptr++;
        end
        cyc++;
    endtask

    task automatic set_ready(input int mode);
        case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = cyc[0];
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic run_frame(input vec_t v);
        clear_stats();
        if (v.push) begin
            for (int i = 0; i < v.len; i++)
                push_word(v.seed ^ (64'(i) * 64'h0101010101010101), i == v.len - 1);
        end
        hold_empty = (v.empty_cyc > 0);
        start      = 1'b1;
        frame_len  = 16'(v.len);
        set_ready(v.ready_mode);
        tick();
        start     = 1'b0;
        frame_len = 16'hBEEF;
        chk({v.name, "_busy"}, busy, 1);
        for (int k = 0; k < 3000 && done_count == 0; k++) begin
            hold_empty = (v.empty_cyc > 0) && (cyc <= v.empty_cyc);
            start      = v.busy_start && (cyc == 3);
            frame_len  = start ? 16'd7 : 16'hBEEF;
            set_ready(v.ready_mode);
            tick();
        end
        start      = 1'b0;
        hold_empty = 1'b0;
        out_ready  = 1'b1;
        tick();
        tick();
        chk({v.name, "_idle"}, busy, 0);
        chk({v.name, "_done_cnt"}, done_count, 1);
        chk({v.name, "_rd_cnt"}, rd_count, v.exp_rd);
        chk({v.name, "_acc_cnt"}, acc_count, v.exp_acc);
        chk({v.name, "_last_cnt"}, last_count, v.exp_last);
        chk({v.name, "_sb_empty"}, exp_q.size(), 0);
        if (v.exp_first != -2) chk({v.name, "_first_valid"}, first_valid, v.exp_first);
        if (v.len > 0) chk({v.name, "_done_cyc"}, done_cyc, last_acc_cyc + 1);
        else           chk({v.name, "_done_cyc"}, done_cyc, 1);
    endtask

    task automatic check_outputs_zero(input string name);
        chk({name, "_valid"}, out_valid, 0);
        chk({name, "_last"}, out_last, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_done"}, done, 0);
        chk({name, "_data"}, out_data, 0);
        chk({name, "_rd_en"}, fifo_rd_en, 0);
    endtask

    initial begin
        vec_t v;
        nchk = 0; npass = 0;
        rst_n = 1'b0; start = 1'b0; frame_len = '0; out_ready = 1'b0;
        hold_empty = 1'b0; wr_ptr = 0; rd_ptr = 0; fifo_dout = '0;
        prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
        clear_stats();

        vecs[0] = '{"basic",        1, 0, 0, 64'h0807060504030201, 1'b0, 1'b1, 1,  8, 1,  3};
        vecs[1] = '{"empty_wait",   3, 5, 0, 64'h8899AABBCCDDEEF0, 1'b1, 1'b1, 3, 24, 1,  8};
        vecs[2] = '{"backpressure", 1, 0, 1, 64'hF1E2D3C4B5A69788, 1'b1, 1'b1, 1,  8, 1,  3};
        vecs[3] = '{"zero_len",     0, 0, 0, 64'h0,                1'b0, 1'b1, 0,  0, 0, -1};
        vecs[4] = '{"random_ready", 4, 0, 2, 64'h0123456789ABCDEF, 1'b1, 1'b1, 4, 32, 1,  3};
        vecs[5] = '{"gap_toggle",   2, 2, 1, 64'h5A5AA5A5C3C33C3C, 1'b1, 1'b1, 2, 16, 1,  5};

        tick();
        tick();
        check_outputs_zero("reset");
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) run_frame(vecs[i]);

        // Abort mid-frame with reset while element 4 of word 2 is presented
        clear_stats();
        for (int i = 0; i < 3; i++) push_word(64'hA0B0C0D0E0F01020 + 64'(i), i == 2);
        start = 1'b1; frame_len = 16'd3; out_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 500 && acc_count < 11; k++) tick();
        chk("abort_reached", acc_count, 11);
        chk("abort_presenting", out_valid, 1);
        rst_n = 1'b0; out_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        check_outputs_zero("abort");
        chk("abort_fifo_untouched", wr_ptr - rd_ptr, 1);
        exp_q.delete();
        expect_word(mem[rd_ptr[7:0]], 1'b1);
        tick();
        chk("abort_no_done", done_count, 0);
        v = '{"after_abort", 1, 0, 0, 64'h0, 1'b1, 1'b0, 1, 8, 1, 3};
        run_frame(v);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
